// File: rtl/rc5_cipher_if.sv
// rc5_cipher_if: command, data and scan signals of the RC5 engine.
// The master side drives commands and data; the slave (the cipher core) answers with status and results.
interface rc5_cipher_if;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic         load_key;
  logic         key_ready;
  logic         start_encrypt;
  logic         start_decrypt;
  logic [31:0]  d_in;
  logic [31:0]  d_out;
  logic         done;
  logic         scan_en;
  logic         scan_in;
  logic         begin_validate;
  logic         scan_out;

  modport master (
    output num_rounds, key, load_key, start_encrypt, start_decrypt, d_in,
           scan_en, scan_in, begin_validate,
    input  key_ready, d_out, done, scan_out
  );

  modport slave (
    input  num_rounds, key, load_key, start_encrypt, start_decrypt, d_in,
           scan_en, scan_in, begin_validate,
    output key_ready, d_out, done, scan_out
  );
endinterface

// File: rtl/rc5_cipher.sv
// rc5_cipher: RC5-16/r/16 engine with on-chip key expansion and one-block encrypt/decrypt.
// Define RC5_SCAN_EN to build the serial scan/validation port; otherwise scan_out is tied low.
module rc5_cipher (
  input  logic        clk,
  input  logic        rst,
  rc5_cipher_if.slave bus
);
  localparam logic [15:0] P = 16'hB7E1;
  localparam logic [15:0] Q = 16'h9E37;

  typedef enum logic [2:0] {IDLE, INIT, MIX, PRE, ROUND, POST} state_t;

  function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] t;
    t = {x, x} << n;
    return t[31:16];
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] t;
    t = {x, x} >> n;
    return t[15:0];
  endfunction

  state_t       state_q, state_d;
  logic [4:0]   rounds_q, rounds_d;
  logic [15:0]  a_q, a_d, b_q, b_d;
  logic [5:0]   idx_q, idx_d;
  logic [2:0]   j_q, j_d;
  logic [7:0]   step_q, step_d;
  logic [4:0]   round_q, round_d;
  logic         decrypt_q, decrypt_d;
  logic         keyReady_q, keyReady_d;
  logic         done_q, done_d;
  logic [31:0]  dOut_q, dOut_d;

  logic [15:0]  sTab [64];
  logic [15:0]  lTab [8];

  logic [127:0] keyEff;
  logic [31:0]  dInEff;
  logic [4:0]   roundsEff;
  logic         cmdLoad, cmdEnc, cmdDec;

  logic         sWe, lWe, lLoad, startAccept;
  logic [5:0]   sAddr;
  logic [15:0]  sData, lData;
  logic [15:0]  mixA, mixB, mixSum, preA, preB, encA, encB, decA, decB;

  logic [6:0]   tCount;
  logic [6:0]   tMax;
  logic [7:0]   mixCount;

  // t = 2(r+1) table entries; the mixing pass runs 3*max(t,8) steps.
  assign tCount   = {1'b0, rounds_q, 1'b0} + 7'd2;
  assign tMax     = (tCount < 7'd8) ? 7'd8 : tCount;
  assign mixCount = {1'b0, tMax} + {tMax, 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rounds_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      j_q        <= '0;
      step_q     <= '0;
      round_q    <= '0;
      decrypt_q  <= 1'b0;
      keyReady_q <= 1'b0;
      done_q     <= 1'b0;
      dOut_q     <= '0;
    end else begin
      state_q    <= state_d;
      rounds_q   <= rounds_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      j_q        <= j_d;
      step_q     <= step_d;
      round_q    <= round_d;
      decrypt_q  <= decrypt_d;
      keyReady_q <= keyReady_d;
      done_q     <= done_d;
      dOut_q     <= dOut_d;
    end
  end

  // The tables hold no reset; key_ready alone says whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (sWe) sTab[sAddr] <= sData;
    if (lLoad) begin
      for (int k = 0; k < 8; k++) lTab[k] <= keyEff[16*k +: 16];
    end else if (lWe) begin
      lTab[j_q] <= lData;
    end
  end

  always_comb begin
    state_d     = state_q;
    rounds_d    = rounds_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    j_d         = j_q;
    step_d      = step_q;
    round_d     = round_q;
    decrypt_d   = decrypt_q;
    keyReady_d  = keyReady_q;
    done_d      = done_q;
    dOut_d      = dOut_q;
    sWe         = 1'b0;
    sAddr       = idx_q;
    sData       = '0;
    lWe         = 1'b0;
    lLoad       = 1'b0;
    lData       = '0;
    startAccept = 1'b0;
    mixA        = '0;
    mixB        = '0;
    mixSum      = '0;
    preA        = '0;
    preB        = '0;
    encA        = '0;
    encB        = '0;
    decA        = '0;
    decB        = '0;

    case (state_q)
      IDLE: begin
        if (cmdLoad) begin
          rounds_d   = roundsEff;
          keyReady_d = 1'b0;
          done_d     = 1'b0;
          lLoad      = 1'b1;
          idx_d      = '0;
          a_d        = P;
          state_d    = INIT;
        end else if ((cmdEnc || cmdDec) && keyReady_q) begin
          startAccept = 1'b1;
          done_d      = 1'b0;
          a_d         = dInEff[15:0];
          b_d         = dInEff[31:16];
          decrypt_d   = !cmdEnc;
          if (cmdEnc) begin
            state_d = PRE;
          end else begin
            round_d = rounds_q;
            state_d = (rounds_q == 5'd0) ? POST : ROUND;
          end
        end
      end

      // a_q carries the running P + i*Q value while the table is seeded.
      INIT: begin
        sWe   = 1'b1;
        sData = a_q;
        a_d   = a_q + Q;
        idx_d = idx_q + 6'd1;
        if ({1'b0, idx_q} == tCount - 7'd1) begin
          idx_d   = '0;
          j_d     = '0;
          step_d  = '0;
          a_d     = '0;
          b_d     = '0;
          state_d = MIX;
        end
      end

      MIX: begin
        mixA   = rotl(sTab[idx_q] + a_q + b_q, 4'd3);
        mixSum = mixA + b_q;
        mixB   = rotl(lTab[j_q] + mixSum, mixSum[3:0]);
        sWe    = 1'b1;
        sData  = mixA;
        lWe    = 1'b1;
        lData  = mixB;
        a_d    = mixA;
        b_d    = mixB;
        j_d    = j_q + 3'd1;
        idx_d  = ({1'b0, idx_q} == tCount - 7'd1) ? 6'd0 : idx_q + 6'd1;
        step_d = step_q + 8'd1;
        if (step_q == mixCount - 8'd1) begin
          keyReady_d = 1'b1;
          state_d    = IDLE;
        end
      end

      PRE: begin
        preA = a_q + sTab[0];
        preB = b_q + sTab[1];
        a_d  = preA;
        b_d  = preB;
        if (rounds_q == 5'd0) begin
          dOut_d  = {preB, preA};
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          round_d = 5'd1;
          state_d = ROUND;
        end
      end

      // Encryption counts the round index up from 1; decryption counts it down to 1.
      ROUND: begin
        if (!decrypt_q) begin
          encA    = rotl(a_q ^ b_q, b_q[3:0]) + sTab[{round_q, 1'b0}];
          encB    = rotl(b_q ^ encA, encA[3:0]) + sTab[{round_q, 1'b1}];
          a_d     = encA;
          b_d     = encB;
          round_d = round_q + 5'd1;
          if (round_q == rounds_q) begin
            dOut_d  = {encB, encA};
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          decB    = rotr(b_q - sTab[{round_q, 1'b1}], a_q[3:0]) ^ a_q;
          decA    = rotr(a_q - sTab[{round_q, 1'b0}], decB[3:0]) ^ decB;
          a_d     = decA;
          b_d     = decB;
          round_d = round_q - 5'd1;
          if (round_q == 5'd1) state_d = POST;
        end
      end

      POST: begin
        preB    = b_q - sTab[1];
        preA    = a_q - sTab[0];
        dOut_d  = {preB, preA};
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.key_ready = keyReady_q;
  assign bus.done      = done_q;
  assign bus.d_out     = dOut_q;

`ifdef RC5_SCAN_EN
  logic [167:0] scanIn_q;
  logic [32:0]  scanOut_q;
  logic         bvPrev_q, pendEnc_q, pendDec_q;
  logic         bvRise;

  // In validation mode the scan register stands in for the parallel data and command pins.
  assign bvRise       = bus.begin_validate & ~bvPrev_q;
  assign keyEff       = bus.begin_validate ? scanIn_q[127:0]   : bus.key;
  assign dInEff       = bus.begin_validate ? scanIn_q[159:128] : bus.d_in;
  assign roundsEff    = bus.begin_validate ? scanIn_q[164:160] : bus.num_rounds;
  assign cmdLoad      = bus.begin_validate ? (bvRise & scanIn_q[165]) : bus.load_key;
  assign cmdEnc       = bus.begin_validate ? pendEnc_q : bus.start_encrypt;
  assign cmdDec       = bus.begin_validate ? pendDec_q : bus.start_decrypt;
  assign bus.scan_out = scanOut_q[32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scanIn_q  <= '0;
      scanOut_q <= '0;
      bvPrev_q  <= 1'b0;
      pendEnc_q <= 1'b0;
      pendDec_q <= 1'b0;
    end else begin
      bvPrev_q <= bus.begin_validate;
      if (bus.scan_en && !bus.begin_validate) scanIn_q <= {scanIn_q[166:0], bus.scan_in};
      if (!bus.scan_en) scanOut_q <= {done_q, dOut_q};
      else if (bus.begin_validate) scanOut_q <= {scanOut_q[31:0], 1'b0};
      // The armed start waits out any key expansion and fires once the table is valid.
      if (!bus.begin_validate) begin
        pendEnc_q <= 1'b0;
        pendDec_q <= 1'b0;
      end else if (bvRise) begin
        pendEnc_q <= scanIn_q[166];
        pendDec_q <= scanIn_q[167];
      end else if (startAccept) begin
        pendEnc_q <= 1'b0;
        pendDec_q <= 1'b0;
      end
    end
  end
`else
  logic unusedScanPins;

  assign unusedScanPins = bus.scan_en ^ bus.scan_in ^ bus.begin_validate ^ startAccept;
  assign keyEff         = bus.key;
  assign dInEff         = bus.d_in;
  assign roundsEff      = bus.num_rounds;
  assign cmdLoad        = bus.load_key;
  assign cmdEnc         = bus.start_encrypt;
  assign cmdDec         = bus.start_decrypt;
  assign bus.scan_out   = 1'b0;
`endif
endmodule

// File: tb/tb_rc5_cipher.sv
// tb_rc5_cipher: directed bench for rc5_cipher, checked against a software RC5-16 model.
// Covers reset, key expansion latency, encrypt/decrypt round trip, ignored commands and the scan port.
module tb_rc5_cipher;
  localparam logic [127:0] KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [31:0]  PT  = 32'hD87FAB42;
  localparam logic [15:0]  P   = 16'hB7E1;
  localparam logic [15:0]  Q   = 16'h9E37;

  logic clk;
  logic rst;
  rc5_cipher_if bus();

  rc5_cipher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0]  refS [64];
  logic [31:0]  ct31;
  logic [31:0]  ct0;
  logic [167:0] scanVec;
  logic [32:0]  shiftBits;
  int           cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rol16(input logic [15:0] x, input int n);
    int s;
    s = n % 16;
    if (s == 0) return x;
    return (x << s) | (x >> (16 - s));
  endfunction

  // Straight software form of the RC5 key schedule, filling refS.
  task automatic refExpand(input logic [127:0] k, input int r);
    logic [15:0] L [8];
    logic [15:0] A, B, sum;
    int t, n, i, j;
    t = 2 * (r + 1);
    n = 3 * ((t > 8) ? t : 8);
    for (int x = 0; x < 8; x++) L[x] = k[16*x +: 16];
    refS[0] = P;
    for (int x = 1; x < t; x++) refS[x] = refS[x-1] + Q;
    A = 16'h0; B = 16'h0; i = 0; j = 0;
    for (int s = 0; s < n; s++) begin
      A       = rol16(refS[i] + A + B, 3);
      refS[i] = A;
      sum     = A + B;
      B       = rol16(L[j] + sum, int'(sum[3:0]));
      L[j]    = B;
      i       = (i + 1) % t;
      j       = (j + 1) % 8;
    end
  endtask

  function automatic logic [31:0] refEncrypt(input logic [31:0] pt, input int r);
    logic [15:0] A, B;
    A = pt[15:0] + refS[0];
    B = pt[31:16] + refS[1];
    for (int i = 1; i <= r; i++) begin
      A = rol16(A ^ B, int'(B[3:0])) + refS[2*i];
      B = rol16(B ^ A, int'(A[3:0])) + refS[2*i+1];
    end
    return {B, A};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a command for exactly one rising edge; the data pins stay as left.
  task automatic applyStimulus(input logic ld, input logic en, input logic de,
                               input logic [31:0] din, input logic [4:0] r);
    @(negedge clk);
    bus.key           = KEY;
    bus.d_in          = din;
    bus.num_rounds    = r;
    bus.load_key      = ld;
    bus.start_encrypt = en;
    bus.start_decrypt = de;
    @(posedge clk);
    #1;
    bus.load_key      = 1'b0;
    bus.start_encrypt = 1'b0;
    bus.start_decrypt = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.done !== 1'b1 && n < limit);
  endtask

  task automatic waitKeyReady(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.key_ready !== 1'b1 && n < limit);
  endtask

  initial begin
    rst                = 1'b0;
    bus.num_rounds     = 5'd0;
    bus.key            = '0;
    bus.load_key       = 1'b0;
    bus.start_encrypt  = 1'b0;
    bus.start_decrypt  = 1'b0;
    bus.d_in           = '0;
    bus.scan_en        = 1'b0;
    bus.scan_in        = 1'b0;
    bus.begin_validate = 1'b0;

    refExpand(KEY, 31);
    ct31 = refEncrypt(PT, 31);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_key_ready", 64'(bus.key_ready), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_d_out", 64'(bus.d_out), 64'd0);
    checkOutput("reset_scan_out", 64'(bus.scan_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Start with no valid key table is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, PT, 5'd31);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("nokey_done", 64'(bus.done), 64'd0);
    checkOutput("nokey_d_out", 64'(bus.d_out), 64'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, PT, 5'd31);
    waitKeyReady(400, cycles);
    checkOutput("keyexp_r31_cycles", 64'(cycles), 64'd256);
    checkOutput("keyexp_r31_ready", 64'(bus.key_ready), 64'd1);

    applyStimulus(1'b0, 1'b1, 1'b0, PT, 5'd31);
    waitDone(100, cycles);
    checkOutput("enc_r31_cycles", 64'(cycles), 64'd32);
    checkOutput("enc_r31_ct", 64'(bus.d_out), 64'(ct31));
    checkOutput("enc_ct_differs", 64'(bus.d_out !== PT), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_sticky", 64'(bus.done), 64'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, ct31, 5'd31);
    waitDone(100, cycles);
    checkOutput("dec_r31_cycles", 64'(cycles), 64'd32);
    checkOutput("dec_r31_pt", 64'(bus.d_out), 64'(PT));

    // Both starts together: encrypt wins; a load pulse mid-operation is ignored.
    applyStimulus(1'b0, 1'b1, 1'b1, PT, 5'd31);
    applyStimulus(1'b1, 1'b0, 1'b1, ct31, 5'd31);
    waitDone(100, cycles);
    checkOutput("prio_busy_cycles", 64'(cycles), 64'd31);
    checkOutput("prio_enc_ct", 64'(bus.d_out), 64'(ct31));
    checkOutput("busy_load_ignored", 64'(bus.key_ready), 64'd1);

    // Reset during key expansion must abort it for good.
    applyStimulus(1'b1, 1'b0, 1'b0, PT, 5'd31);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset_key_ready", 64'(bus.key_ready), 64'd0);
    checkOutput("midreset_d_out", 64'(bus.d_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("midreset_aborted", 64'(bus.key_ready), 64'd0);

`ifdef RC5_SCAN_EN
    scanVec = {1'b0, 1'b1, 1'b1, 5'd31, PT, KEY};
    for (int i = 167; i >= 0; i--) begin
      @(negedge clk);
      bus.scan_en = 1'b1;
      bus.scan_in = scanVec[i];
      @(posedge clk);
    end
    @(negedge clk);
    bus.scan_en        = 1'b0;
    bus.scan_in        = 1'b0;
    bus.d_in           = 32'h0;
    bus.begin_validate = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    checkOutput("scan_par_ct", 64'(bus.d_out), 64'(ct31));
    bus.scan_en = 1'b1;
    for (int i = 32; i >= 0; i--) begin
      shiftBits[i] = bus.scan_out;
      @(posedge clk);
      @(negedge clk);
    end
    bus.scan_en        = 1'b0;
    bus.begin_validate = 1'b0;
    checkOutput("scan_done_bit", 64'(shiftBits[32]), 64'd1);
    checkOutput("scan_ct", 64'(shiftBits[31:0]), 64'(ct31));
`else
    @(negedge clk);
    bus.scan_en        = 1'b1;
    bus.scan_in        = 1'b1;
    bus.begin_validate = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("noscan_scan_out", 64'(bus.scan_out), 64'd0);
    checkOutput("noscan_no_load", 64'(bus.key_ready), 64'd0);
    @(negedge clk);
    bus.scan_en        = 1'b0;
    bus.scan_in        = 1'b0;
    bus.begin_validate = 1'b0;
`endif

    refExpand(KEY, 0);
    ct0 = {PT[31:16] + refS[1], PT[15:0] + refS[0]};
    applyStimulus(1'b1, 1'b0, 1'b0, PT, 5'd0);
    waitKeyReady(100, cycles);
    checkOutput("keyexp_r0_cycles", 64'(cycles), 64'd26);
    applyStimulus(1'b0, 1'b1, 1'b0, PT, 5'd0);
    waitDone(10, cycles);
    checkOutput("enc_r0_cycles", 64'(cycles), 64'd1);
    checkOutput("enc_r0_ct", 64'(bus.d_out), 64'(ct0));
    applyStimulus(1'b0, 1'b0, 1'b1, ct0, 5'd0);
    waitDone(10, cycles);
    checkOutput("dec_r0_cycles", 64'(cycles), 64'd1);
    checkOutput("dec_r0_pt", 64'(bus.d_out), 64'(PT));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
